// File: rtl/msj_angle_spi_reader.sv
// Round-robin SPI mode-1 master polling AS5048-style 14-bit angle sensors.
// Optional feature macro MSJ_ANGLE_ERRCNT_EN adds saturating per-sensor error counters.
module msj_angle_spi_reader #(
  parameter int NUM_SENSORS = 8,
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      angle_miso,
  output logic                      angle_mosi,
  output logic                      angle_sck,
  output logic [NUM_SENSORS-1:0]    angle_ss_n_o,
  output logic [14*NUM_SENSORS-1:0] angles,
  output logic [NUM_SENSORS-1:0]    angle_valid,
  output logic                      sweep_done,
  output logic                      busy
`ifdef MSJ_ANGLE_ERRCNT_EN
  ,
  output logic [16*NUM_SENSORS-1:0] error_count
`endif
);

  localparam int              IW       = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0]     GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_SENSORS - 1);
  localparam logic [15:0]     TX_WORD  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic [15:0]            cnt_r, cnt_s;
  logic [3:0]             bit_r, bit_s;
  logic                   phase_r, phase_s;
  logic [IW-1:0]          idx_r, idx_s;
  logic [15:0]            rx_r, rx_s;
  logic                   done_s, done_r;
  logic                   eval_r;
  logic [NUM_SENSORS-1:0] sel_s, ss_n_r;
  logic                   sck_r, mosi_r, busy_r;
  logic [13:0]            ang_r [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] valid_r;
`ifdef MSJ_ANGLE_ERRCNT_EN
  logic [15:0]            err_r [NUM_SENSORS];
`endif

  function automatic logic even_parity(input logic [15:0] w);
    return ~(^w);
  endfunction

  // Bit 14 is the sensor's error flag; the word must also carry even parity.
  function automatic logic frame_ok(input logic [15:0] w);
    return even_parity(w) && (w[14] == 1'b0);
  endfunction

  // Next-state, counters and receive shift register.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + 16'd1;
    bit_s   = bit_r;
    phase_s = phase_r;
    idx_s   = idx_r;
    rx_s    = rx_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = 16'd0;
        if (enable) begin
          idx_s   = '0;
          state_s = CS_SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      CS_SETUP: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s   = 16'd0;
          bit_s   = 4'd0;
          phase_s = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = CS_SETUP;
        end
      end
      SHIFT: begin
        // phase 1 = sck high half; sample miso at the edge where sck falls
        if (cnt_r == DIV_LAST) begin
          cnt_s = 16'd0;
          if (phase_r) begin
            phase_s = 1'b0;
            rx_s    = {rx_r[14:0], angle_miso};
          end else if (bit_r == 4'd15) begin
            state_s = CS_HOLD;
          end else begin
            bit_s   = bit_r + 4'd1;
            phase_s = 1'b1;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      CS_HOLD: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s   = 16'd0;
          state_s = GAP;
        end else begin
          state_s = CS_HOLD;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s = 16'd0;
          if (idx_r != IDX_LAST) begin
            idx_s   = idx_r + IW'(1);
            state_s = CS_SETUP;
          end else begin
            done_s  = 1'b1;
            idx_s   = '0;
            state_s = enable ? CS_SETUP : IDLE;
          end
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        cnt_s   = 16'd0;
        state_s = IDLE;
      end
    endcase
  end

  // One-hot-low select for the state being entered.
  always_comb begin
    sel_s = '1;
    if ((state_s == CS_SETUP) || (state_s == SHIFT) || (state_s == CS_HOLD)) begin
      sel_s[idx_s] = 1'b0;
    end else begin
      sel_s = '1;
    end
  end

  // FSM registers and registered bus pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      bit_r   <= 4'd0;
      phase_r <= 1'b0;
      idx_r   <= '0;
      rx_r    <= 16'd0;
      eval_r  <= 1'b0;
      done_r  <= 1'b0;
      ss_n_r  <= '1;
      sck_r   <= 1'b0;
      mosi_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      phase_r <= phase_s;
      idx_r   <= idx_s;
      rx_r    <= rx_s;
      // results land one cycle after the select rises
      eval_r  <= (state_r == CS_HOLD) && (state_s == GAP);
      done_r  <= done_s;
      ss_n_r  <= sel_s;
      sck_r   <= (state_s == SHIFT) && phase_s;
      busy_r  <= (state_s != IDLE);
      if (state_s != SHIFT) begin
        mosi_r <= 1'b0;
      end else if (phase_s && !phase_r) begin
        mosi_r <= TX_WORD[~bit_s];
      end else begin
        mosi_r <= mosi_r;
      end
    end
  end

  // Per-sensor result registers, written once per completed frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        ang_r[i] <= 14'd0;
`ifdef MSJ_ANGLE_ERRCNT_EN
        err_r[i] <= 16'd0;
`endif
      end
      valid_r <= '0;
    end else if (eval_r) begin
      if (frame_ok(rx_r)) begin
        ang_r[idx_r]   <= rx_r[13:0];
        valid_r[idx_r] <= 1'b1;
      end else begin
        valid_r[idx_r] <= 1'b0;
`ifdef MSJ_ANGLE_ERRCNT_EN
        if (err_r[idx_r] != 16'hFFFF) begin
          err_r[idx_r] <= err_r[idx_r] + 16'd1;
        end else begin
          err_r[idx_r] <= err_r[idx_r];
        end
`endif
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_pack
    assign angles[14*g +: 14] = ang_r[g];
`ifdef MSJ_ANGLE_ERRCNT_EN
    assign error_count[16*g +: 16] = err_r[g];
`endif
  end

  assign angle_ss_n_o = ss_n_r;
  assign angle_sck    = sck_r;
  assign angle_mosi   = mosi_r;
  assign angle_valid  = valid_r;
  assign sweep_done   = done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_msj_angle_spi_reader.sv
// Randomized bench for msj_angle_spi_reader: sweep-timeline model, reactive sensor, per-cycle compare.
module tb_msj_angle_spi_reader;
  localparam int N     = 8;
  localparam int CD    = 4;
  localparam int GAPC  = 8;
  localparam int FRAME = 34*CD + GAPC;
  localparam int SWEEP = N*FRAME;

  logic clock = 1'b0;
  logic reset, enable, angle_miso;
  logic angle_mosi, angle_sck, sweep_done, busy;
  logic [N-1:0] angle_ss_n_o, angle_valid;
  logic [14*N-1:0] angles;
`ifdef MSJ_ANGLE_ERRCNT_EN
  logic [16*N-1:0] error_count;
`endif

  msj_angle_spi_reader #(.NUM_SENSORS(N), .CLK_DIV(CD), .GAP_CYCLES(GAPC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .angle_miso(angle_miso),
    .angle_mosi(angle_mosi), .angle_sck(angle_sck), .angle_ss_n_o(angle_ss_n_o),
    .angles(angles), .angle_valid(angle_valid), .sweep_done(sweep_done), .busy(busy)
`ifdef MSJ_ANGLE_ERRCNT_EN
    , .error_count(error_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: position k inside the current sweep ----------------
  bit live = 0, running = 0;
  int k = 0, sweep_no = 0, f = 0, c = 0;
  logic [15:0] cur_word = 16'h0;
  logic [N-1:0] exp_ss = '1, exp_val = '0;
  logic exp_sck = 1'b0, exp_mosi = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic [14*N-1:0] exp_ang = '0;
  logic [16*N-1:0] exp_err = '0;

  function automatic logic [15:0] pick(input int sw, input int s);
    logic [13:0] a;
    int kind;
    if (sw == 0 && s == 0) return 16'h9234;
    if (sw == 0 && s == 3) return 16'h3FFF;
    if (sw == 0 && s == 5) return 16'h7FFF;
    if (sw == 1 && s == 3) return 16'h1234;
    a = 14'($urandom);
    kind = $urandom_range(0, 3);
    if (kind <= 1) return {^a, 1'b0, a};
    if (kind == 2) return {~(^a), 1'b0, a};
    return {~(^a), 1'b1, a};
  endfunction

  function automatic bit good(input logic [15:0] w);
    return ($countones(w) % 2 == 0) && (w[14] == 1'b0);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      live = 1; running = 0; k = 0;
      exp_ang = '0; exp_val = '0; exp_err = '0; exp_done = 1'b0;
    end else if (live) begin
      exp_done = 1'b0;
      if (!running) begin
        if (enable) begin running = 1; k = 0; end
      end else if (k == SWEEP-1) begin
        exp_done = 1'b1;
        sweep_no++;
        if (enable) k = 0; else running = 0;
      end else begin
        k++;
      end
      if (running) begin
        f = k / FRAME;
        c = k % FRAME;
        if (c == 0) cur_word = pick(sweep_no, f);
        if (c == 34*CD + 1) begin
          if (good(cur_word)) begin
            exp_ang[14*f +: 14] = cur_word[13:0];
            exp_val[f] = 1'b1;
          end else begin
            exp_val[f] = 1'b0;
            if (exp_err[16*f +: 16] != 16'hFFFF) exp_err[16*f +: 16] = exp_err[16*f +: 16] + 16'd1;
          end
        end
      end
    end
    exp_busy = running;
    exp_ss   = '1;
    exp_sck  = 1'b0;
    exp_mosi = 1'b0;
    if (running && c < 34*CD) begin
      exp_ss[f] = 1'b0;
      if (c >= CD && c < 33*CD) begin
        exp_mosi = 1'b1;
        exp_sck  = ((c - CD) % (2*CD)) < CD;
      end
    end
  end

  // ---------------- sensor: shifts out cur_word MSB first, new bit on each sck rise ----------------
  int sbit = 0;
  logic sck_prev = 1'b0;
  always @(negedge clock) begin
    if (angle_ss_n_o === '1) begin
      sbit = 0;
    end else if (angle_sck === 1'b1 && sck_prev === 1'b0 && sbit < 16) begin
      angle_miso = cur_word[15 - sbit];
      sbit++;
    end
    sck_prev = angle_sck;
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clock) begin
    if (live) begin
      check("ss_n", angle_ss_n_o, exp_ss);
      check("sck", angle_sck, exp_sck);
      check("mosi", angle_mosi, exp_mosi);
      check("busy", busy, exp_busy);
      check("sweep_done", sweep_done, exp_done);
      check("angles", angles, exp_ang);
      check("angle_valid", angle_valid, exp_val);
`ifdef MSJ_ANGLE_ERRCNT_EN
      check("error_count", error_count, exp_err);
`endif
      check("one_select", ($countones(~angle_ss_n_o) <= 1), 1'b1);
      check("sck_without_select", (angle_sck === 1'b1 && angle_ss_n_o === '1), 1'b0);
    end
  end

  // ---------------- directed sequence with literal pins ----------------
  initial begin
    bit found;
    reset = 1'b1; enable = 1'b0; angle_miso = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ss", angle_ss_n_o, 8'hFF);
    check("rst_sck", angle_sck, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", angle_valid, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b1;
    repeat (SWEEP) @(negedge clock);
    check("s0_angle", angles[13:0], 14'h1234);
    check("s0_valid", angle_valid[0], 1'b1);
    check("s3_angle", angles[14*3 +: 14], 14'h3FFF);
    check("s3_valid", angle_valid[3], 1'b1);
    check("s5_valid", angle_valid[5], 1'b0);
    check("s5_angle", angles[14*5 +: 14], 14'h0000);
    @(negedge clock);
    check("sweep1_done", sweep_done, 1'b1);
    check("sweep2_first_sel", angle_ss_n_o, 8'hFE);
    repeat (SWEEP-1) @(negedge clock);
    check("s3_angle_kept", angles[14*3 +: 14], 14'h3FFF);
    check("s3_valid_bad", angle_valid[3], 1'b0);
`ifdef MSJ_ANGLE_ERRCNT_EN
    check("s3_errcnt", error_count[16*3 +: 16], 16'd1);
`endif
    repeat (3*SWEEP) @(negedge clock);

    found = 0;
    for (int i = 0; i < SWEEP + 100 && !found; i++) begin
      @(negedge clock);
      if (angle_ss_n_o[2] === 1'b0) found = 1;
    end
    check("wait_sensor2", found, 1'b1);
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < SWEEP + 100 && !found; i++) begin
      @(negedge clock);
      if (busy === 1'b0) found = 1;
    end
    check("wait_idle", found, 1'b1);
    check("stop_done", sweep_done, 1'b1);
    repeat (40) @(negedge clock);
    check("idle_ss", angle_ss_n_o, 8'hFF);
    check("idle_sck", angle_sck, 1'b0);

    enable = 1'b1;
    found = 0;
    for (int i = 0; i < SWEEP + 100 && !found; i++) begin
      @(negedge clock);
      if (angle_ss_n_o[4] === 1'b0) found = 1;
    end
    check("wait_sensor4", found, 1'b1);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ss", angle_ss_n_o, 8'hFF);
    check("midrst_sck", angle_sck, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_angles", angles, 112'h0);
    check("midrst_valid", angle_valid, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    check("restart_sel0", angle_ss_n_o, 8'hFE);
    repeat (SWEEP + 50) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
